// File: rtl/uart_bus_bridge.sv
// UART byte-stream command decoder that masters single read/write register-bus cycles.
// 'W' addr data -> bus write + ACK; 'R' addr -> bus read + data bytes; bad or errored bytes -> NAK.
module uart_bus_bridge #(
  parameter int AddrBytes     = 2,
  parameter int DataBytes     = 4,
  parameter int TimeoutCycles = 5000000
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [7:0]               rx_data_i,
  input  logic                     rx_data_valid_i,
  input  logic                     rx_frame_error_i,
  input  logic                     rx_parity_error_i,
  output logic [7:0]               tx_data_o,
  output logic                     tx_data_valid_o,
  input  logic                     tx_data_in_ready_i,
  output logic [8*AddrBytes-1:0]   bus_addr_o,
  output logic [8*DataBytes-1:0]   bus_wdata_o,
  output logic                     bus_we_o,
  output logic                     bus_req_o,
  input  logic [8*DataBytes-1:0]   bus_rdata_i,
  input  logic                     bus_ack_i,
  output logic                     busy_o
);

  localparam int AW = 8 * AddrBytes;
  localparam int DW = 8 * DataBytes;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADDR = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] BUS  = 3'd3;
  localparam logic [2:0] SEND = 3'd4;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  logic [2:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] resp_q, resp_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [31:0]   timer_q, timer_d;

  logic rx_clean;
  logic rx_bad;
  logic expire;

  assign rx_clean = rx_data_valid_i && !rx_frame_error_i && !rx_parity_error_i;
  assign rx_bad   = rx_data_valid_i && (rx_frame_error_i || rx_parity_error_i);
  assign expire   = (TimeoutCycles != 0) && (timer_q == 32'(TimeoutCycles - 1));

  // The response shifts out of the top byte of resp_q; cnt_q doubles as the
  // frame byte counter and the count of response bytes still to send.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        timer_d = 32'd0;
        cnt_d   = 3'd0;
        if (rx_clean && (rx_data_i == CMD_WR || rx_data_i == CMD_RD)) begin
          state_d = ADDR;
          we_d    = (rx_data_i == CMD_WR);
        end else if (rx_data_valid_i) begin
          state_d = SEND;
          resp_d  = DW'(NAK) << (DW - 8);
          cnt_d   = 3'd1;
        end
      end
      ADDR: begin
        if (rx_bad) begin
          state_d = SEND;
          resp_d  = DW'(NAK) << (DW - 8);
          cnt_d   = 3'd1;
        end else if (rx_clean) begin
          addr_d  = (addr_q << 8) | AW'(rx_data_i);
          timer_d = 32'd0;
          if (cnt_q == 3'(AddrBytes - 1)) begin
            cnt_d   = 3'd0;
            state_d = we_q ? DATA : BUS;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else if (expire) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      DATA: begin
        if (rx_bad) begin
          state_d = SEND;
          resp_d  = DW'(NAK) << (DW - 8);
          cnt_d   = 3'd1;
        end else if (rx_clean) begin
          wdata_d = (wdata_q << 8) | DW'(rx_data_i);
          timer_d = 32'd0;
          if (cnt_q == 3'(DataBytes - 1)) begin
            cnt_d   = 3'd0;
            state_d = BUS;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else if (expire) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      BUS: begin
        if (bus_ack_i) begin
          state_d = SEND;
          if (we_q) begin
            resp_d = DW'(ACK) << (DW - 8);
            cnt_d  = 3'd1;
          end else begin
            resp_d = bus_rdata_i;
            cnt_d  = 3'(DataBytes);
          end
        end
      end
      SEND: begin
        if (tx_data_in_ready_i) begin
          resp_d = resp_q << 8;
          cnt_d  = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      cnt_q   <= 3'd0;
      timer_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
    end
  end

  assign tx_data_o       = resp_q[DW-1 -: 8];
  assign tx_data_valid_o = (state_q == SEND);
  assign bus_addr_o      = addr_q;
  assign bus_wdata_o     = wdata_q;
  assign bus_we_o        = we_q;
  assign bus_req_o       = (state_q == BUS);
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge: directed and randomized command frames
// checked against a frame-level model of the expected bus cycle and response bytes.
module tb_uart_bus_bridge;

  localparam int AB = 2;
  localparam int DB = 4;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [7:0]    rx_data_i;
  logic          rx_data_valid_i;
  logic          rx_frame_error_i;
  logic          rx_parity_error_i;
  logic [7:0]    tx_data_o;
  logic          tx_data_valid_o;
  logic          tx_data_in_ready_i;
  logic [8*AB-1:0] bus_addr_o;
  logic [8*DB-1:0] bus_wdata_o;
  logic          bus_we_o;
  logic          bus_req_o;
  logic [8*DB-1:0] bus_rdata_i;
  logic          bus_ack_i;
  logic          busy_o;

  int checks = 0;
  int failures = 0;
  int reqCount = 0;
  int txValidCycles = 0;
  logic reqPrev = 1'b0;
  logic [7:0] expResp[$];

  uart_bus_bridge #(
    .AddrBytes(AB),
    .DataBytes(DB),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .rx_data_i(rx_data_i),
    .rx_data_valid_i(rx_data_valid_i),
    .rx_frame_error_i(rx_frame_error_i),
    .rx_parity_error_i(rx_parity_error_i),
    .tx_data_o(tx_data_o),
    .tx_data_valid_o(tx_data_valid_o),
    .tx_data_in_ready_i(tx_data_in_ready_i),
    .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_we_o(bus_we_o),
    .bus_req_o(bus_req_o),
    .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Passive observers: count request pulses and cycles with a response byte on offer.
  always @(negedge clk) begin
    if (bus_req_o === 1'b1 && reqPrev !== 1'b1) reqCount++;
    reqPrev = bus_req_o;
    if (tx_data_valid_o === 1'b1) txValidCycles++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one received byte for exactly one clock; called and returns at a negedge.
  task automatic applyStimulus(input logic [7:0] b, input logic fe, input logic pe);
    rx_data_i         = b;
    rx_data_valid_i   = 1'b1;
    rx_frame_error_i  = fe;
    rx_parity_error_i = pe;
    @(negedge clk);
    rx_data_valid_i   = 1'b0;
    rx_frame_error_i  = 1'b0;
    rx_parity_error_i = 1'b0;
  endtask

  task automatic driveJunk();
    rx_data_i         = 8'($urandom);
    rx_data_valid_i   = 1'b1;
    rx_frame_error_i  = 1'($urandom_range(0, 1));
    rx_parity_error_i = 1'($urandom_range(0, 1));
  endtask

  task automatic clearRx();
    rx_data_valid_i   = 1'b0;
    rx_frame_error_i  = 1'b0;
    rx_parity_error_i = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_tx_data"}, tx_data_o, 0);
    checkOutput({tag, "_tx_valid"}, tx_data_valid_o, 0);
    checkOutput({tag, "_addr"}, bus_addr_o, 0);
    checkOutput({tag, "_wdata"}, bus_wdata_o, 0);
    checkOutput({tag, "_we"}, bus_we_o, 0);
    checkOutput({tag, "_req"}, bus_req_o, 0);
    checkOutput({tag, "_busy"}, busy_o, 0);
  endtask

  // Expects bus_req_o already up; holds off the ack for lat cycles, then acks once.
  task automatic runBus(input logic [15:0] ea, input logic [31:0] ew, input logic ewe,
                        input logic [31:0] rdata, input int lat, input bit junk);
    checkOutput("bus_req_rise", bus_req_o, 1);
    checkOutput("bus_addr", bus_addr_o, ea);
    checkOutput("bus_we", bus_we_o, ewe);
    if (ewe) checkOutput("bus_wdata", bus_wdata_o, ew);
    checkOutput("busy_bus", busy_o, 1);
    for (int i = 0; i < lat; i++) begin
      if (junk) driveJunk();
      @(negedge clk);
      clearRx();
      checkOutput("bus_req_hold", bus_req_o, 1);
      checkOutput("bus_addr_hold", bus_addr_o, ea);
    end
    bus_rdata_i = rdata;
    bus_ack_i   = 1'b1;
    @(negedge clk);
    bus_ack_i   = 1'b0;
    bus_rdata_i = $urandom;
    checkOutput("bus_req_fall", bus_req_o, 0);
    checkOutput("tx_valid_rise", tx_data_valid_o, 1);
  endtask

  // Drains expResp through the TX handshake, holding ready low readyLow cycles per byte.
  task automatic collectResp(input int readyLow, input bit junk);
    for (int k = 0; k < expResp.size(); k++) begin
      for (int c = 0; c < readyLow; c++) begin
        checkOutput("tx_valid_wait", tx_data_valid_o, 1);
        checkOutput("tx_data_stable", tx_data_o, expResp[k]);
        if (junk) driveJunk();
        @(negedge clk);
        clearRx();
      end
      checkOutput("tx_valid", tx_data_valid_o, 1);
      checkOutput("tx_data", tx_data_o, expResp[k]);
      tx_data_in_ready_i = 1'b1;
      @(negedge clk);
      tx_data_in_ready_i = 1'b0;
    end
    checkOutput("busy_fall", busy_o, 0);
    checkOutput("tx_valid_fall", tx_data_valid_o, 0);
  endtask

  // Frame-level model: builds the byte list, decides NAK versus bus cycle, and
  // derives the expected response bytes directly from the command rules.
  task automatic runFrame(input logic [7:0] cmd, input logic [15:0] addr, input logic [31:0] wdata,
                          input int errPos, input bit errFrame, input logic [31:0] rdata,
                          input int lat, input int readyLow, input bit junk);
    logic [7:0] frameBytes[$];
    bit isCmd;
    bit nak;
    int n;
    int startReq;
    isCmd = (cmd == 8'h57) || (cmd == 8'h52);
    frameBytes.push_back(cmd);
    if (isCmd) begin
      for (int i = 0; i < AB; i++) frameBytes.push_back(8'(addr >> (8 * (AB - 1 - i))));
      if (cmd == 8'h57)
        for (int i = 0; i < DB; i++) frameBytes.push_back(8'(wdata >> (8 * (DB - 1 - i))));
    end
    nak = !isCmd || (errPos >= 0 && errPos < frameBytes.size());
    n = (errPos >= 0 && errPos < frameBytes.size()) ? errPos + 1 : frameBytes.size();
    startReq = reqCount;
    for (int i = 0; i < n; i++)
      applyStimulus(frameBytes[i], (i == errPos) && errFrame, (i == errPos) && !errFrame);
    expResp.delete();
    if (nak) begin
      checkOutput("nak_no_req", bus_req_o, 0);
      expResp.push_back(8'h15);
    end else begin
      runBus(addr, wdata, cmd == 8'h57, rdata, lat, junk);
      if (cmd == 8'h57) expResp.push_back(8'h06);
      else for (int i = 0; i < DB; i++) expResp.push_back(8'(rdata >> (8 * (DB - 1 - i))));
    end
    collectResp(readyLow, junk);
    checkOutput("req_count", reqCount - startReq, nak ? 0 : 1);
  endtask

  initial begin
    logic [7:0]  cmd;
    logic [31:0] rd;
    int kind;
    int errPos;
    int startReq;
    int startTx;

    reset_i            = 1'b1;
    rx_data_i          = 8'h00;
    rx_data_valid_i    = 1'b0;
    rx_frame_error_i   = 1'b0;
    rx_parity_error_i  = 1'b0;
    tx_data_in_ready_i = 1'b0;
    bus_rdata_i        = '0;
    bus_ack_i          = 1'b0;
    idleCycles(2);
    checkResetOutputs("reset");
    reset_i = 1'b0;
    idleCycles(1);

    $display("[TB] directed write, read, unknown command, errored address byte");
    runFrame(8'h57, 16'h1234, 32'hDEADBEEF, -1, 1'b0, 32'h0, 2, 0, 1'b1);
    runFrame(8'h52, 16'h0010, 32'h0, -1, 1'b0, 32'hCAFEF00D, 1, 3, 1'b1);
    runFrame(8'h41, 16'h0, 32'h0, -1, 1'b0, 32'h0, 0, 1, 1'b0);
    runFrame(8'h52, 16'h0010, 32'h0, 2, 1'b0, 32'h0, 0, 0, 1'b0);
    runFrame(8'h57, 16'hABCD, 32'h12345678, -1, 1'b0, 32'h0, 0, 0, 1'b0);

    $display("[TB] inter-byte timeout");
    startReq = reqCount;
    startTx  = txValidCycles;
    applyStimulus(8'h57, 1'b0, 1'b0);
    applyStimulus(8'h12, 1'b0, 1'b0);
    idleCycles(TO - 1);
    checkOutput("timeout_not_yet", busy_o, 1);
    idleCycles(1);
    checkOutput("timeout_busy", busy_o, 0);
    checkOutput("timeout_no_tx", tx_data_valid_o, 0);
    checkOutput("timeout_req_count", reqCount - startReq, 0);
    checkOutput("timeout_tx_cycles", txValidCycles - startTx, 0);

    applyStimulus(8'h52, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
    idleCycles(TO - 1);
    checkOutput("gap99_busy", busy_o, 1);
    applyStimulus(8'h10, 1'b0, 1'b0);
    rd = $urandom;
    runBus(16'h0010, 32'h0, 1'b0, rd, 0, 1'b0);
    expResp.delete();
    for (int i = 0; i < DB; i++) expResp.push_back(8'(rd >> (8 * (DB - 1 - i))));
    collectResp(0, 1'b0);

    $display("[TB] randomized frames");
    for (int f = 0; f < 16; f++) begin
      kind   = $urandom_range(0, 3);
      errPos = -1;
      cmd    = ($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52;
      if (kind == 2) begin
        do cmd = 8'($urandom); while (cmd == 8'h57 || cmd == 8'h52);
      end
      if (kind == 3) errPos = $urandom_range(0, (cmd == 8'h57) ? AB + DB : AB);
      runFrame(cmd, 16'($urandom), $urandom, errPos, 1'($urandom_range(0, 1)), $urandom,
               $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset during bus request");
    applyStimulus(8'h52, 1'b0, 1'b0);
    applyStimulus(8'h55, 1'b0, 1'b0);
    applyStimulus(8'hAA, 1'b0, 1'b0);
    checkOutput("rst_bus_req_up", bus_req_o, 1);
    reset_i = 1'b1;
    @(negedge clk);
    checkResetOutputs("rst_bus");
    reset_i     = 1'b0;
    bus_rdata_i = 32'h11223344;
    bus_ack_i   = 1'b1;
    @(negedge clk);
    bus_ack_i   = 1'b0;
    checkOutput("late_ack_req", bus_req_o, 0);
    checkOutput("late_ack_tx", tx_data_valid_o, 0);
    checkOutput("late_ack_busy", busy_o, 0);

    $display("[TB] reset during response");
    applyStimulus(8'h52, 1'b0, 1'b0);
    applyStimulus(8'h01, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b0, 1'b0);
    runBus(16'h0102, 32'h0, 1'b0, 32'h89ABCDEF, 0, 1'b0);
    checkOutput("rst_send_first", tx_data_o, 8'h89);
    tx_data_in_ready_i = 1'b1;
    @(negedge clk);
    tx_data_in_ready_i = 1'b0;
    checkOutput("rst_send_second", tx_data_o, 8'hAB);
    reset_i = 1'b1;
    @(negedge clk);
    checkResetOutputs("rst_send");
    reset_i = 1'b0;
    idleCycles(1);
    checkResetOutputs("rst_send_after");
    runFrame(8'h57, 16'h0F0F, 32'hA5A55A5A, -1, 1'b0, 32'h0, 1, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
